// File: rtl/jk_ubus_pkg.sv
// Shared types and helpers for the UBUS central arbiter: bus phase encoding
// and beat-count arithmetic derived from the transfer size field.
package jk_ubus_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } jk_ubus_phase_e;

    localparam int MAX_BEATS = 8;
    localparam int BEAT_W    = $clog2(MAX_BEATS) + 1;

    typedef logic [BEAT_W-1:0] beat_t;

    // size 0..3 selects a 1, 2, 4 or 8 beat transfer.
    function automatic beat_t beats_from_size(input logic [1:0] size);
        return beat_t'(1) << size;
    endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so the search
// starts just above ptr, take the lowest set bit, then map back to a master.
module jk_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    shift;
    logic [IW:0]    pick;
    logic [IW:0]    sum_raw;

    assign dbl     = {req, req};
    assign shift   = {1'b0, ptr} + (IW+1)'(1);
    assign any_req = |req;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = dbl[i + int'(shift)];
        end
    end

    // Scan downward so the lowest set rotated bit wins.
    always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick = (IW+1)'(i);
            end
        end
    end

    assign sum_raw = shift + pick;
    assign winner  = IW'((sum_raw >= (IW+1)'(N)) ? (sum_raw - (IW+1)'(N)) : sum_raw);

endmodule

// File: rtl/jk_ubus_arbiter.sv
// UBUS central controller: ARB -> ADDR -> DATA sequencing with round-robin
// grant. Optional data-beat watchdog enabled by JK_UBUS_ARB_TIMEOUT_EN.
module jk_ubus_arbiter
    import jk_ubus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   start,
    input  logic                   read,
    input  logic                   write,
    input  logic [1:0]             size,
    input  logic                   bip,
    input  logic                   wait_state,
    input  logic                   error,
    output logic                   xfer_done,
    output logic                   proto_err,
    output logic                   timeout
);

    localparam int IW = $clog2(NUM_MASTERS);

    jk_ubus_phase_e state_reg, state_next;

    logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
    logic [NUM_MASTERS-1:0] winner_onehot;
    logic                   start_reg, start_next;
    logic                   xfer_done_reg, xfer_done_next;
    logic                   proto_err_reg, proto_err_next;

    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] winner;
    logic          any_req;
    beat_t         beat_cnt_reg;
    beat_t         expected_reg;
    beat_t         beat_last;

    logic grant_go;
    logic addr_valid;
    logic addr_both;
    logic beat_done;
    logic beat_final;
    logic beat_bad;
    logic to_hit;
    logic terminate;

    jk_rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == IW'(gi));
        end
    endgenerate

    // start_reg gates arbitration so every grant follows a visible start cycle,
    // including the first ARB cycle after reset.
    assign grant_go   = start_reg && any_req;
    assign addr_valid = read ^ write;
    assign addr_both  = read & write;
    assign beat_done  = !wait_state;
    assign beat_last  = beat_cnt_reg + beat_t'(1);
    assign beat_final = beat_done && (!bip || (beat_last == expected_reg));
    assign beat_bad   = beat_done && (bip ? (beat_last == expected_reg)
                                          : (beat_last != expected_reg));
    assign terminate  = error || beat_final || to_hit;

`ifdef JK_UBUS_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] wait_cnt_reg;
    logic [TW:0]   wait_cnt_inc;
    logic          timeout_reg, timeout_next;

    assign wait_cnt_inc = {1'b0, wait_cnt_reg} + (TW+1)'(1);
    assign to_hit       = wait_state && (wait_cnt_inc >= (TW+1)'(TIMEOUT));
    assign timeout_next = (state_reg == DATA) && !error && to_hit;
    assign timeout      = timeout_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= timeout_next;
            if ((state_reg == DATA) && wait_state && !terminate) begin
                wait_cnt_reg <= wait_cnt_reg + TW'(1);
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end
`else
    // No watchdog: wait_state may stall forever; constant 0 for any legal TIMEOUT.
    assign to_hit  = 1'b0;
    assign timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ARB;
            gnt_reg       <= '0;
            start_reg     <= 1'b0;
            xfer_done_reg <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            start_reg     <= start_next;
            xfer_done_reg <= xfer_done_next;
            proto_err_reg <= proto_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB:     state_next = grant_go ? ADDR : ARB;
            ADDR:    state_next = addr_valid ? DATA : ARB;
            DATA:    state_next = terminate ? ARB : DATA;
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        gnt_next       = '0;
        xfer_done_next = 1'b0;
        proto_err_next = 1'b0;
        start_next     = (state_next == ARB);
        case (state_reg)
            ARB: begin
                if (grant_go) begin
                    gnt_next = winner_onehot;
                end
            end
            ADDR: begin
                if (addr_valid) begin
                    gnt_next = gnt_reg;
                end
                proto_err_next = addr_both;
            end
            DATA: begin
                if (!terminate) begin
                    gnt_next = gnt_reg;
                end
                xfer_done_next = terminate;
                // A slave error ends the transfer outright; beat accounting is moot.
                proto_err_next = !error && beat_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= IW'(NUM_MASTERS - 1);
            beat_cnt_reg <= '0;
            expected_reg <= beat_t'(1);
        end else begin
            if ((state_reg == ARB) && grant_go) begin
                rr_ptr_reg <= winner;
            end
            if (state_reg == ADDR) begin
                beat_cnt_reg <= '0;
                expected_reg <= beats_from_size(size);
            end else if ((state_reg == DATA) && beat_done && !terminate) begin
                beat_cnt_reg <= beat_last;
            end
        end
    end

    assign gnt       = gnt_reg;
    assign start     = start_reg;
    assign xfer_done = xfer_done_reg;
    assign proto_err = proto_err_reg;

endmodule
